// File: rtl/rxadc_pkg.sv
// Shared constants for the rxadc SPI register bank: word addresses,
// STATUS bit positions and the default identification word.
package rxadc_pkg;

   typedef enum logic [6:0] {
      ADDR_ID      = 7'd0,
      ADDR_CTRL    = 7'd1,
      ADDR_NCO     = 7'd2,
      ADDR_STATUS  = 7'd3,
      ADDR_FIFO    = 7'd4,
      ADDR_SCRATCH = 7'd5
   } reg_addr_e;

   localparam int unsigned ST_EMPTY  = 0;
   localparam int unsigned ST_FULL   = 1;
   localparam int unsigned ST_OVF    = 2;
   localparam int unsigned ST_UDF    = 3;
   localparam int unsigned ST_LVL_LO = 8;
   localparam int unsigned ST_LVL_HI = 15;

   localparam logic [31:0] ID_VAL_DEF = 32'h52584132;

endpackage

// File: rtl/spi_regs_if.sv
// Strobe/data bundle between the SPI slave (master modport) and the
// register bank (slave modport).
interface spi_regs_if #(
   parameter int ASZ = 7,
   parameter int DSZ = 32
);
   logic           we;
   logic           re;
   logic [ASZ-1:0] addr;
   logic [DSZ-1:0] wdat;
   logic [DSZ-1:0] rdat;

   modport master (output we, output re, output addr, output wdat, input rdat);
   modport slave  (input we, input re, input addr, input wdat, output rdat);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a separate level counter
// and one-cycle overflow/underflow event pulses.
module sync_fifo #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          ovf_pulse,
   output logic          udf_pulse
);
   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

   logic [DW-1:0] mem_r [0:DEPTH-1];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   level_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Flag and accept decode; a push into a full FIFO is allowed only when a pop frees a slot.
   always_comb begin
      empty     = (level_r == {(AW+1){1'b0}});
      full      = (level_r == DEPTH_L);
      do_pop_s  = pop & ~empty;
      do_push_s = push & (~full | pop);
      ovf_pulse = push & full & ~pop;
      udf_pulse = pop & empty;
   end

   assign dout  = mem_r[rptr_r];
   assign level = level_r;

   // Storage write port; contents need no reset since level gates visibility.
   always_ff @(posedge clk) begin
      if (reset && do_push_s) begin
         mem_r[wptr_r] <= din;
      end
   end

   // Pointers and level counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         level_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) wptr_r <= wptr_r + 1'b1;
         if (do_pop_s)  rptr_r <= rptr_r + 1'b1;
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + 1'b1;
            2'b01:   level_r <= level_r - 1'b1;
            default: level_r <= level_r;
         endcase
      end
   end
endmodule

// File: rtl/spi_regs.sv
// SPI-facing register bank for rxadc. Define SPI_REGS_FIFO_EN to build the
// capture FIFO, STATUS flags and the pop-on-read path at address 4.
module spi_regs
   import rxadc_pkg::*;
#(
   parameter int          ASZ     = 7,
   parameter int          DSZ     = 32,
   parameter int          FIFO_AW = 4,
   parameter logic [31:0] ID_VAL  = ID_VAL_DEF
) (
   input  logic           clk,
   input  logic           reset,
   spi_regs_if.slave      bus,
   input  logic           cap_valid,
   input  logic [DSZ-1:0] cap_data,
   output logic [DSZ-1:0] ctrl,
   output logic [DSZ-1:0] nco_freq
);
   logic [DSZ-1:0] ctrl_r;
   logic [DSZ-1:0] nco_r;
   logic [DSZ-1:0] scratch_r;
   logic [DSZ-1:0] status_s;
   logic [DSZ-1:0] fifo_rd_s;
   logic [DSZ-1:0] rdat_s;

   // Read/write control registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_r    <= {DSZ{1'b0}};
         nco_r     <= {DSZ{1'b0}};
         scratch_r <= {DSZ{1'b0}};
      end else if (bus.we) begin
         case (bus.addr)
            ASZ'(ADDR_CTRL):    ctrl_r    <= bus.wdat;
            ASZ'(ADDR_NCO):     nco_r     <= bus.wdat;
            ASZ'(ADDR_SCRATCH): scratch_r <= bus.wdat;
            default:            ;
         endcase
      end
   end

   assign ctrl     = ctrl_r;
   assign nco_freq = nco_r;

`ifdef SPI_REGS_FIFO_EN
   logic [2:0]     re_sync_r;
   logic           pop_s;
   logic           st_wr_s;
   logic           ovf_r;
   logic           udf_r;
   logic [DSZ-1:0] fifo_dout_s;
   logic           fifo_empty_s;
   logic           fifo_full_s;
   logic [FIFO_AW:0] fifo_level_s;
   logic           ovf_pulse_s;
   logic           udf_pulse_s;

   // re comes from the SPI clock domain; s[2] is the edge-detect delay stage.
   always_ff @(posedge clk) begin
      if (!reset) re_sync_r <= 3'b000;
      else        re_sync_r <= {re_sync_r[1:0], bus.re};
   end

   // Pop lands after the slave has sampled the head word for this transfer.
   assign pop_s   = re_sync_r[1] & ~re_sync_r[2] & (bus.addr == ASZ'(ADDR_FIFO));
   assign st_wr_s = bus.we & (bus.addr == ASZ'(ADDR_STATUS));

   sync_fifo #(.DW(DSZ), .AW(FIFO_AW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cap_valid),
      .din       (cap_data),
      .pop       (pop_s),
      .dout      (fifo_dout_s),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s),
      .level     (fifo_level_s),
      .ovf_pulse (ovf_pulse_s),
      .udf_pulse (udf_pulse_s)
   );

   // Sticky flags: a new event in the same cycle as a W1C clear keeps the bit set.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_pulse_s | (ovf_r & ~(st_wr_s & bus.wdat[ST_OVF]));
         udf_r <= udf_pulse_s | (udf_r & ~(st_wr_s & bus.wdat[ST_UDF]));
      end
   end

   // STATUS word assembly.
   always_comb begin
      status_s                      = {DSZ{1'b0}};
      status_s[ST_EMPTY]            = fifo_empty_s;
      status_s[ST_FULL]             = fifo_full_s;
      status_s[ST_OVF]              = ovf_r;
      status_s[ST_UDF]              = udf_r;
      status_s[ST_LVL_HI:ST_LVL_LO] = 8'(fifo_level_s);
      fifo_rd_s                     = fifo_dout_s;
   end
`else
   logic                unused_in_s;
   logic [FIFO_AW:0]    unused_level_s;

   assign unused_in_s    = ^{cap_valid, cap_data, bus.re};
   assign unused_level_s = {(FIFO_AW+1){1'b0}};

   // Without the FIFO, STATUS and the FIFO window read as zero.
   always_comb begin
      status_s  = {DSZ{1'b0}};
      fifo_rd_s = {DSZ{1'b0}};
   end
`endif

   // Read mux; combinational so the slave sees the head word before the pop.
   always_comb begin
      case (bus.addr)
         ASZ'(ADDR_ID):      rdat_s = DSZ'(ID_VAL);
         ASZ'(ADDR_CTRL):    rdat_s = ctrl_r;
         ASZ'(ADDR_NCO):     rdat_s = nco_r;
         ASZ'(ADDR_STATUS):  rdat_s = status_s;
         ASZ'(ADDR_FIFO):    rdat_s = fifo_rd_s;
         ASZ'(ADDR_SCRATCH): rdat_s = scratch_r;
         default:            rdat_s = {DSZ{1'b0}};
      endcase
   end

   assign bus.rdat = rdat_s;
endmodule

// File: tb/tb_spi_regs.sv
// Self-checking bench for spi_regs: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_spi_regs;
`ifdef SPI_REGS_FIFO_EN
   localparam bit FIFO_EN = 1'b1;
`else
   localparam bit FIFO_EN = 1'b0;
`endif
   localparam logic [31:0] ID = 32'h52584132;

   logic        clk = 1'b0;
   logic        reset;
   logic        cap_valid;
   logic [31:0] cap_data;
   logic [31:0] ctrl;
   logic [31:0] nco_freq;

   spi_regs_if #(.ASZ(7), .DSZ(32)) bus ();

   spi_regs #(.ASZ(7), .DSZ(32), .FIFO_AW(4), .ID_VAL(ID)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .cap_valid (cap_valid),
      .cap_data  (cap_data),
      .ctrl      (ctrl),
      .nco_freq  (nco_freq)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [31:0] m_q [$];
   bit          m_ovf, m_udf;
   logic [31:0] m_ctrl, m_nco, m_scr;
   int          m_age;
   bit          m_prev_re;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_rdat(input logic [6:0] a);
      int sz = m_q.size();
      case (a)
         7'd0: return ID;
         7'd1: return m_ctrl;
         7'd2: return m_nco;
         7'd3: return FIFO_EN ? ((32'(sz) << 8) | (32'(m_udf) << 3) | (32'(m_ovf) << 2)
                                 | (32'(sz == 16) << 1) | 32'(sz == 0)) : 32'h0;
         7'd4: return (FIFO_EN && sz > 0) ? m_q[0] : 32'h0;
         7'd5: return m_scr;
         default: return 32'h0;
      endcase
   endfunction

   // One clock: drive at negedge, update model at posedge, compare shortly after.
   task automatic tick(input bit rst_v, input bit we_v, input logic [6:0] a,
                       input logic [31:0] wd, input bit cv, input logic [31:0] cd,
                       input bit re_v);
      bit pop_now, set_o, set_u;
      @(negedge clk);
      reset = ~rst_v; bus.we = we_v; bus.addr = a; bus.wdat = wd;
      cap_valid = cv; cap_data = cd; bus.re = re_v;
      @(posedge clk);
      if (rst_v) begin
         m_q.delete(); m_ovf = 0; m_udf = 0;
         m_ctrl = 0; m_nco = 0; m_scr = 0; m_age = 0; m_prev_re = 0;
      end else begin
         set_o = 0; set_u = 0; pop_now = 0;
         if (FIFO_EN) begin
            // a read transfer pops on the third clock edge that sees re high
            if (m_age > 0) m_age++;
            if (re_v && !m_prev_re) m_age = 1;
            m_prev_re = re_v;
            pop_now = (m_age == 3) && (a == 7'd4);
            if (pop_now && m_q.size() == 0) begin
               set_u = 1;
               if (cv) m_q.push_back(cd);
            end else if (pop_now) begin
               void'(m_q.pop_front());
               if (cv) m_q.push_back(cd);
            end else if (cv) begin
               if (m_q.size() == 16) set_o = 1;
               else m_q.push_back(cd);
            end
            if (we_v && a == 7'd3) begin
               m_ovf = set_o | (m_ovf & ~wd[2]);
               m_udf = set_u | (m_udf & ~wd[3]);
            end else begin
               m_ovf = m_ovf | set_o;
               m_udf = m_udf | set_u;
            end
         end
         if (we_v && a == 7'd1) m_ctrl = wd;
         if (we_v && a == 7'd2) m_nco  = wd;
         if (we_v && a == 7'd5) m_scr  = wd;
      end
      #1;
      if (!(FIFO_EN && a == 7'd4 && m_q.size() == 0))
         check($sformatf("rdat@%0d", a), bus.rdat, exp_rdat(a));
      check("ctrl", ctrl, m_ctrl);
      check("nco", nco_freq, m_nco);
   endtask

   task automatic idle(input logic [6:0] a);
      tick(0, 0, a, 32'h0, 0, 32'h0, 0);
   endtask

   task automatic push_word(input logic [31:0] d);
      tick(0, 0, 7'd3, 32'h0, 1, d, 0);
   endtask

   task automatic spi_read(input logic [6:0] a);
      for (int i = 0; i < 3; i++) tick(0, 0, a, 32'h0, 0, 32'h0, 1);
      for (int i = 0; i < 3; i++) tick(0, 0, a, 32'h0, 0, 32'h0, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rst_exp [8];
      bit re_v;
      int hold;
      logic [6:0] cur_a;
      rst_exp = '{ID, 32'h0, 32'h0, (FIFO_EN ? 32'h1 : 32'h0), 32'h0, 32'h0, 32'h0, 32'h0};
      reset = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = 7'd0;
      bus.wdat = 32'h0; cap_valid = 1'b0; cap_data = 32'h0;

      // reset values
      tick(1, 0, 7'd0, 32'h0, 0, 32'h0, 0);
      tick(1, 0, 7'd0, 32'h0, 0, 32'h0, 0);
      for (int a = 0; a < 8; a++) begin
         idle(7'(a));
         check($sformatf("rst_sweep%0d", a), bus.rdat, rst_exp[a]);
      end
      check("ctrl_rst", ctrl, 32'h0);

      // write/read back; ID and unmapped writes are ignored
      tick(0, 1, 7'd1, 32'hDEADBEEF, 0, 32'h0, 0);
      check("ctrl_wr", ctrl, 32'hDEADBEEF);
      tick(0, 1, 7'd2, 32'h0BADF00D, 0, 32'h0, 0);
      tick(0, 1, 7'd0, 32'h12345678, 0, 32'h0, 0);
      tick(0, 1, 7'd7, 32'h87654321, 0, 32'h0, 0);
      tick(0, 1, 7'd4, 32'h55555555, 0, 32'h0, 0);
      idle(7'd0);
      check("id_ro", bus.rdat, ID);
      idle(7'd7);
      check("addr7_zero", bus.rdat, 32'h0);
      idle(7'd1);
      check("ctrl_rb", bus.rdat, 32'hDEADBEEF);

      // FIFO ordering
      push_word(32'd1); push_word(32'd2); push_word(32'd3);
      for (int i = 0; i < 3; i++) begin
         idle(7'd4);
         check("order", bus.rdat, FIFO_EN ? 32'(i + 1) : 32'h0);
         spi_read(7'd4);
      end
      idle(7'd3);
      check("order_status", bus.rdat, FIFO_EN ? 32'h1 : 32'h0);

      // overflow
      for (int i = 0; i < 17; i++) push_word(32'(i));
      idle(7'd3);
      check("ovf_status", bus.rdat, FIFO_EN ? 32'h1006 : 32'h0);
      for (int i = 0; i < 16; i++) begin
         idle(7'd4);
         check("drain", bus.rdat, FIFO_EN ? 32'(i) : 32'h0);
         spi_read(7'd4);
      end
      tick(0, 1, 7'd3, 32'h4, 0, 32'h0, 0);
      check("ovf_clear", bus.rdat, FIFO_EN ? 32'h1 : 32'h0);

      // underflow
      spi_read(7'd4);
      idle(7'd3);
      check("udf_status", bus.rdat, FIFO_EN ? 32'h9 : 32'h0);
      tick(0, 1, 7'd3, 32'h8, 0, 32'h0, 0);

      // full + push coincident with pop
      for (int i = 0; i < 16; i++) push_word(32'(100 + i));
      tick(0, 0, 7'd4, 32'h0, 0, 32'h0, 1);
      tick(0, 0, 7'd4, 32'h0, 0, 32'h0, 1);
      tick(0, 0, 7'd4, 32'h0, 1, 32'hAAAA5555, 1);
      for (int i = 0; i < 3; i++) idle(7'd4);
      check("simul_head", bus.rdat, FIFO_EN ? 32'd101 : 32'h0);
      idle(7'd3);
      check("simul_status", bus.rdat, FIFO_EN ? 32'h1002 : 32'h0);

      // long re: one pop only
      tick(1, 0, 7'd0, 32'h0, 0, 32'h0, 0);
      push_word(32'd5); push_word(32'd6);
      for (int i = 0; i < 20; i++) tick(0, 0, 7'd4, 32'h0, 0, 32'h0, 1);
      for (int i = 0; i < 3; i++) idle(7'd4);
      idle(7'd3);
      check("long_re", bus.rdat, FIFO_EN ? 32'h100 : 32'h0);

      // reset between re rising and the pop
      push_word(32'd7);
      tick(0, 0, 7'd4, 32'h0, 0, 32'h0, 1);
      for (int i = 0; i < 3; i++) tick(1, 0, 7'd4, 32'h0, 1, 32'h99, 0);
      for (int i = 0; i < 4; i++) idle(7'd4);
      idle(7'd3);
      check("midrst", bus.rdat, FIFO_EN ? 32'h1 : 32'h0);

      // random traffic
      re_v = 0; hold = 0; cur_a = 7'd4;
      for (int n = 0; n < 600; n++) begin
         if (!re_v && hold == 0 && (m_age == 0 || m_age > 4) && $urandom_range(0, 3) == 0)
            cur_a = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 7)) : 7'd4;
         if (hold == 0) begin
            re_v = ~re_v;
            hold = $urandom_range(2, 5);
         end
         hold--;
         tick(0, ($urandom_range(0, 7) == 0), cur_a, $urandom,
              ($urandom_range(0, 4) == 0), $urandom, re_v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_regs.md
# spi_regs

Register bank and capture FIFO sitting directly downstream of the SPI slave in the rxadc design. Consumes the slave's `we`/`re`/`addr`/`wdat` strobes and returns `rdat`. Holds the DSP control words and a pop-on-read FIFO that drains sample captures to the host over SPI. All logic runs in the system clock domain except the `re` strobe, which it synchronizes internally.

## Interface
- `ASZ`, 7: address width; matches the SPI slave.
- `DSZ`, 32: data width.
- `FIFO_AW`, 4: FIFO address bits; depth is 2^FIFO_AW = 16.
- `ID_VAL`, 32'h52584132: read-only identification word.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `we`  in  1  one-`clk` write pulse from the SPI slave, already in the `clk` domain.
- `re`  in  1  read strobe from the SPI slave, in the SPI clock domain.
- `addr`  in  ASZ  register address; stable from address phase to end of transfer.
- `wdat`  in  DSZ  write data; stable while `we` is high.
- `rdat`  out  DSZ  read data; combinational from `addr` and register state.
- `cap_valid`  in  1  capture push strobe from the DSP.
- `cap_data`  in  DSZ  capture word.
- `ctrl`  out  DSZ  control register.
- `nco_freq`  out  DSZ  NCO frequency word.

## Operation
- **Address map (word addresses)**
  - 0 `ID`: read-only; returns `ID_VAL`.
  - 1 `CTRL`: read/write.
  - 2 `NCO`: read/write.
  - 3 `STATUS`: read-only except bits 2 and 3.
    - bit0 empty, bit1 full, bit2 sticky overflow, bit3 sticky underflow.
    - [15:8] FIFO level, range 0..16.
    - Bits 2 and 3 are write-1-to-clear.
  - 4 `FIFO`: read returns the head word; a read pops it. Writes are ignored.
  - 5 `SCRATCH`: read/write.
  - 6..127: read 0, writes ignored.
- **Write**
  - On a `clk` edge with `we`=1, the addressed register is updated with `wdat`.
- **Read**
  - `rdat` is a pure mux of the addressed register.
  - The SPI slave samples `rdat` on the SPI falling edge after `re`. The FIFO head must therefore remain unchanged until the pop below.
- **Pop**
  - `re` passes through a 3-flop synchronizer `s[2:0]`.
  - `pop` = `s[1] & ~s[2] & (addr==4)`, giving exactly one pop per SPI read transfer.
- **FIFO**
  - Synchronous, first-word-fall-through.
  - Push when `cap_valid`=1.
  - Full with no pop: the push is dropped and overflow is set.
  - Pop when empty: no change except underflow is set.
  - Push and pop together when full: both occur, level stays 16.
  - Push and pop together when empty: push only, underflow is set.
  - Read and write pointers wrap modulo 16. The level is a separate 5-bit counter.
- **Sticky bits**
  - If a set and a W1C clear occur in the same cycle, the set wins.

## Timing
- **Reset** (`reset`=0 at a `clk` edge):
  - `ctrl`=0, `nco_freq`=0, scratch=0.
  - FIFO empty: pointers and level 0.
  - Sticky bits 0; synchronizer flops 0.
  - `rdat` then reads: `ID_VAL` at addr 0, 32'h1 at addr 3, 0 elsewhere.
- **Reset mid-operation**
  - A push in the same cycle as reset is discarded.
  - A pending `re` in the synchronizer is discarded.
- **Write latency**
  - `ctrl`/`nco_freq` show the new value 1 `clk` after the edge that samples `we`.
- **Pop latency**
  - Pop occurs 2–3 `clk` edges after `re` rises.
  - The new head is visible on `rdat` the cycle after the pop.
- **Push latency**
  - Data pushed at edge N is readable and included in the level at N+1.
- **Constraint on `re`**
  - `re` must be held high or low for at least 2 `clk` periods. The SPI clock must run ≤ `clk`/4.

## Configuration
- **`SPI_REGS_FIFO_EN` defined:**
  - FIFO, STATUS flags and address 4 behave as above.
- **`SPI_REGS_FIFO_EN` not defined:**
  - No FIFO storage is generated and `cap_valid`/`cap_data` are ignored.
  - Address 4 reads 0 and STATUS reads 0.
  - The `re` synchronizer is removed.
  - All other registers are unchanged.

## Structure
- **Shared package `rxadc_pkg`**
  - Address constants: `ADDR_ID`, `ADDR_CTRL`, `ADDR_NCO`, `ADDR_STATUS`, `ADDR_FIFO`, `ADDR_SCRATCH`.
  - STATUS bit-position constants.
  - Default `ID_VAL`.
- **Sub-module `sync_fifo`** (parameters `DW`, `AW`)
  - Ports: `push`, `din`, `pop`, `dout`, `empty`, `full`, `level`, `ovf_pulse`, `udf_pulse`.
  - `spi_regs` owns the sticky bits and the register decode.

## Test plan
- **Reset values:** assert reset, release, sweep `addr` 0..7.
  - Expect `rdat` = 32'h52584132, 0, 0, 32'h1, 0, 0, 0, 0.
  - Expect `ctrl`=0.
- **Write/read back:** `we` pulse with addr 1, wdat 32'hDEADBEEF.
  - Expect `ctrl`=32'hDEADBEEF one cycle later and addr 1 reads the same value.
  - Writes to addr 0 and addr 7 change nothing.
- **FIFO ordering:** push 1, 2, 3, then do three `re` pulses at addr 4.
  - `rdat` sequence 1, 2, 3; STATUS level goes 3→0; final STATUS = 32'h1.
- **Overflow:** push 17 words (0..16).
  - STATUS = 32'h1006 (full, overflow set, level 16).
  - Draining returns 0..15; word 16 is lost.
  - Writing 32'h4 to STATUS clears overflow.
- **Underflow and simultaneous events:**
  - Pop when empty: STATUS bit3 set, level 0.
  - With FIFO full, `cap_valid` coincident with pop: level stays 16, overflow not set.
- **Long `re` and mid-op reset:**
  - Hold `re` high for 20 `clk` cycles: exactly one pop.
  - Assert reset between `re` rising and the pop: FIFO empty, no pop afterwards.
